// File: rtl/gpu_alu_pkg.sv
// rtl/gpu_alu_pkg.sv - shared types, funct codes and decode for the filter GPU ALU
package gpu_alu_pkg;

    typedef enum logic [2:0] {
        CTRL_ADD,
        CTRL_SUB,
        CTRL_MUL,
        CTRL_CONV,
        CTRL_MOV,
        CTRL_ILLEGAL
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_e;

    localparam logic [2:0] FUNCT_SUB  = 3'b001;
    localparam logic [2:0] FUNCT_MUL  = 3'b011;
    localparam logic [2:0] FUNCT_CONV = 3'b100;
    localparam logic [3:0] FUNCT_MOV  = 4'b1010;

    // funct[3] only matters for MOV; every other code ignores it.
    function automatic alu_ctrl_e decode_op(input logic alu_op, input logic [3:0] funct);
        alu_ctrl_e c;
        if (!alu_op) begin
            c = CTRL_ADD;
        end else if (funct == FUNCT_MOV) begin
            c = CTRL_MOV;
        end else begin
            case (funct[2:0])
                FUNCT_SUB:  c = CTRL_SUB;
                FUNCT_MUL:  c = CTRL_MUL;
                FUNCT_CONV: c = CTRL_CONV;
                default:    c = CTRL_ILLEGAL;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_lane.sv
// rtl/alu_lane.sv - one combinational pixel lane: ADD/SUB wrap, saturating MUL, MOV
module alu_lane
    import gpu_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_ctrl_e        ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [2*WIDTH-1:0] prod;

    assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);

    always_comb begin
        y = '0;
        case (ctrl)
            CTRL_ADD: y = a + b;
            CTRL_SUB: y = a - b;
            CTRL_MUL: y = (prod[2*WIDTH-1:WIDTH] != '0) ? '1 : prod[WIDTH-1:0];
            CTRL_MOV: y = b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_sequencer.sv
// rtl/alu_exec_sequencer.sv - registered multi-lane ALU with lane-serial CONV multiply-accumulate
module alu_exec_sequencer
    import gpu_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   alu_op,
    input  logic [3:0]             funct,
    input  logic [LANES*WIDTH-1:0] src_a,
    input  logic [LANES*WIDTH-1:0] src_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] result,
    output logic                   illegal,
    output logic                   busy
);

    localparam int ACC_W = 2*WIDTH + $clog2(LANES);
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VEC_W = LANES*WIDTH;
    localparam logic [WIDTH-1:0] LANE_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1);

    state_e            state_q, state_d;
    alu_ctrl_e         ctrl;
    logic [VEC_W-1:0]  op_a_q, op_b_q;
    logic [ACC_W-1:0]  acc_q, acc_next, acc_shift;
    logic [CNT_W-1:0]  cnt_q;
    logic [VEC_W-1:0]  result_q;
    logic              illegal_q;

    logic              load_single, load_conv, mac_step, conv_finish;
    logic [VEC_W-1:0]  lane_y, conv_vec;
    logic [WIDTH-1:0]  mac_a, mac_b, conv_lane;
    logic [2*WIDTH-1:0] mac_prod;

    assign ctrl = decode_op(alu_op, funct);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        alu_lane #(.WIDTH(WIDTH)) u_lane (
            .ctrl (ctrl),
            .a    (src_a[i*WIDTH +: WIDTH]),
            .b    (src_b[i*WIDTH +: WIDTH]),
            .y    (lane_y[i*WIDTH +: WIDTH])
        );
    end

    // One multiplier shared across lanes, selected by the lane counter.
    assign mac_a     = op_a_q[int'(cnt_q)*WIDTH +: WIDTH];
    assign mac_b     = op_b_q[int'(cnt_q)*WIDTH +: WIDTH];
    assign mac_prod  = (2*WIDTH)'(mac_a) * (2*WIDTH)'(mac_b);
    assign acc_next  = acc_q + ACC_W'(mac_prod);
    assign acc_shift = acc_next >> SHIFT;
    assign conv_lane = (acc_shift > ACC_W'(LANE_MAX)) ? LANE_MAX : acc_shift[WIDTH-1:0];

    always_comb begin
        conv_vec = '0;
        conv_vec[WIDTH-1:0] = conv_lane;
    end

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        load_single = 1'b0;
        load_conv   = 1'b0;
        mac_step    = 1'b0;
        conv_finish = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_EXEC: begin
                mac_step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    conv_finish = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A request taken while draining DONE is steered exactly as from IDLE.
        if (in_valid && in_ready) begin
            if (ctrl == CTRL_CONV) begin
                load_conv = 1'b1;
                state_d   = ST_EXEC;
            end else begin
                load_single = 1'b1;
                state_d     = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (load_conv) begin
                op_a_q <= src_a;
                op_b_q <= src_b;
                acc_q  <= '0;
                cnt_q  <= '0;
            end else if (mac_step) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (load_single) begin
                result_q  <= lane_y;
                illegal_q <= (ctrl == CTRL_ILLEGAL);
            end else if (conv_finish) begin
                result_q  <= conv_vec;
                illegal_q <= 1'b0;
            end
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_EXEC);
    assign result    = result_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb/tb_alu_exec_sequencer.sv - randomized and directed bench against a behavioural ALU model
module tb_alu_exec_sequencer;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int SHIFT = 0;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        alu_op;
    logic [3:0]  funct;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_sequencer #(.WIDTH(WIDTH), .LANES(LANES), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
        logic [31:0] v;
        v = {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
        return v;
    endfunction

    // kind: 0 ADD, 1 SUB, 2 MUL, 3 CONV, 4 MOV, 5 illegal
    function automatic void model(input logic op, input logic [3:0] f, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic ill, output logic conv);
        int kind, av, bv, y, acc, fl;
        fl = int'(f) % 8;
        if (!op)              kind = 0;
        else if (f == 4'd10)  kind = 4;
        else if (fl == 1)     kind = 1;
        else if (fl == 3)     kind = 2;
        else if (fl == 4)     kind = 3;
        else                  kind = 5;
        r = 0;
        acc = 0;
        for (int i = 0; i < LANES; i++) begin
            av = int'((a >> (8*i)) & 32'hff);
            bv = int'((b >> (8*i)) & 32'hff);
            y = 0;
            if (kind == 0) y = (av + bv) % 256;
            if (kind == 1) y = (av - bv + 256) % 256;
            if (kind == 2) y = (av * bv > 255) ? 255 : av * bv;
            if (kind == 4) y = bv;
            acc = acc + av * bv;
            r[8*i +: 8] = y[7:0];
        end
        if (kind == 3) begin
            y = acc >> SHIFT;
            if (y > 255) y = 255;
            r = 0;
            r[7:0] = y[7:0];
        end
        ill  = (kind == 5);
        conv = (kind == 3);
    endfunction

    // Issues one op, holds out_ready low for 'stall' cycles after the result appears, then releases it.
    task automatic run_op(input logic op, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int stall, input string tag,
                          output logic [31:0] got);
        logic [31:0] exp_r, held;
        logic        exp_ill, is_conv, held_ill;
        int          lat, busy_n, waited;
        model(op, f, a, b, exp_r, exp_ill, is_conv);
        alu_op = op; funct = f; src_a = a; src_b = b; in_valid = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #2;
            waited++;
        end
        chk({tag, ":in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 1'($urandom); funct = 4'($urandom); src_a = $urandom; src_b = $urandom;
        lat = 1; busy_n = 0;
        while (!out_valid && lat < 50) begin
            if (busy) begin
                busy_n++;
                chk({tag, ":rdy_exec"}, 32'(in_ready), 32'd0);
            end
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ":latency"}, 32'(lat), is_conv ? 32'(LANES + 1) : 32'd1);
        chk({tag, ":busy_cyc"}, 32'(busy_n), is_conv ? 32'(LANES) : 32'd0);
        chk({tag, ":result"}, result, exp_r);
        chk({tag, ":illegal"}, 32'(illegal), 32'(exp_ill));
        got = result;
        held = result; held_ill = illegal;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({tag, ":hold_res"}, result, held);
            chk({tag, ":hold_ill"}, 32'(illegal), 32'(held_ill));
            chk({tag, ":hold_vld"}, 32'(out_valid), 32'd1);
            chk({tag, ":hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] got, exp_r;
        logic        exp_ill, is_conv;
        logic [31:0] sa [3];
        logic [31:0] sb [3];
        logic [3:0]  rf;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 1'b0; funct = 4'd0; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst:out_valid", 32'(out_valid), 32'd0);
        chk("rst:result", result, 32'd0);
        chk("rst:illegal", 32'(illegal), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(1'b1, 4'b0001, pack4(10, 20, 30, 5), pack4(3, 4, 5, 6), 0, "sub", got);
        chk("sub:lit", got, pack4(7, 16, 25, 255));
        run_op(1'b1, 4'b0011, pack4(16, 3, 0, 255), pack4(16, 4, 9, 1), 0, "mul", got);
        chk("mul:lit", got, pack4(255, 12, 0, 255));
        run_op(1'b0, 4'b0000, pack4(200, 1, 2, 3), pack4(100, 1, 1, 1), 0, "add", got);
        chk("add:lane0", {24'd0, got[7:0]}, 32'd44);
        run_op(1'b1, 4'b0100, pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 0, "conv", got);
        chk("conv:lit", got, 32'd10);
        run_op(1'b1, 4'b1100, 32'hffffffff, 32'hffffffff, 0, "conv_sat", got);
        chk("conv_sat:lit", got, 32'd255);

        run_op(1'b0, 4'b0110, pack4(9, 8, 7, 6), pack4(1, 2, 3, 4), 5, "bp", got);

        for (int i = 0; i < 3; i++) begin
            sa[i] = $urandom; sb[i] = $urandom;
        end
        for (int i = 0; i < 3; i++) begin
            alu_op = 1'b0; funct = 4'($urandom); src_a = sa[i]; src_b = sb[i];
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            model(1'b0, 4'd0, sa[i], sb[i], exp_r, exp_ill, is_conv);
            chk("stream:valid", 32'(out_valid), 32'd1);
            chk("stream:result", result, exp_r);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream:drained", 32'(out_valid), 32'd0);

        run_op(1'b1, 4'b0010, 32'h11223344, 32'h55667788, 0, "dec_ill", got);
        chk("dec_ill:lit", got, 32'd0);
        run_op(1'b1, 4'b1010, 32'h11223344, 32'h55667788, 0, "dec_mov", got);
        chk("dec_mov:lit", got, 32'h55667788);
        run_op(1'b1, 4'b1001, pack4(5, 5, 5, 5), pack4(6, 1, 5, 0), 0, "dec_sub9", got);
        chk("dec_sub9:lit", got, pack4(255, 4, 0, 5));
        run_op(1'b0, 4'b0011, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 0, "dec_add", got);
        chk("dec_add:lit", got, pack4(2, 4, 6, 8));

        for (int n = 0; n < 150; n++) begin
            rf = 4'($urandom);
            if ($urandom_range(0, 3) == 0) rf = {1'($urandom), 3'b100};
            run_op(1'($urandom_range(0, 4) != 0), rf, $urandom, $urandom,
                   int'($urandom_range(0, 2)), "rnd", got);
        end

        alu_op = 1'b1; funct = 4'b0100; src_a = 32'h80808080; src_b = 32'h02020202;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("rstc:in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rstc:busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstc:out_valid", 32'(out_valid), 32'd0);
        chk("rstc:result", result, 32'd0);
        chk("rstc:illegal", 32'(illegal), 32'd0);
        chk("rstc:busy0", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rstc:in_ready_rel", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("rstc:no_partial", 32'(out_valid), 32'd0);
        run_op(1'b1, 4'b0001, pack4(10, 20, 30, 5), pack4(3, 4, 5, 6), 0, "post_rst", got);
        chk("post_rst:lit", got, pack4(7, 16, 25, 255));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
